// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the serial subtractor.
// Imported by the interface, slice and top.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_SLICE = 16;

   function automatic int nslice(int w, int s);
      return w / s;
   endfunction

   // Counter needs at least one bit even for a single slice.
   function automatic int cnt_w(int w, int s);
      int n;
      n = w / s;
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_sub_64_if.sv
// Operand/result handshake bundle for seq_sub_64.
// master drives operands and consumes results.
interface seq_sub_64_if
   import sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             zero;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, zero
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, zero
   );

endinterface

// File: rtl/sub_slice.sv
// Combinational SLICE-bit subtractor with borrow in/out.
// Extra MSB of the widened difference is the borrow-out.
module sub_slice #(
   parameter int SLICE = 16
) (
   input  logic [SLICE-1:0] x,
   input  logic [SLICE-1:0] y,
   input  logic             bi,
   output logic [SLICE-1:0] d,
   output logic             bo
);

   assign {bo, d} = {1'b0, x}
                  - {1'b0, y}
                  - {{SLICE{1'b0}}, bi};

endmodule

// File: rtl/seq_sub_64.sv
// Serial a - b - bin, one slice per clock, LSB slice first.
// Single slice subtractor muxed by the slice counter.
module seq_sub_64
   import sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input logic         clk,
   input logic         rst,
   seq_sub_64_if.slave bus
);

   localparam int NSLICE = nslice(WIDTH, SLICE);
   localparam int CW     = cnt_w(WIDTH, SLICE);

   if (WIDTH % SLICE != 0) begin : g_chk
      $error("WIDTH must be a multiple of SLICE");
   end

   state_t                        state;
   logic [NSLICE-1:0][SLICE-1:0]  a_r;
   logic [NSLICE-1:0][SLICE-1:0]  b_r;
   logic [NSLICE-1:0][SLICE-1:0]  diff_r;
   logic [NSLICE-1:0][SLICE-1:0]  diff_nx;
   logic [CW-1:0]                 cnt;
   logic                          borrow;
   logic                          in_ready_r;
   logic                          out_valid_r;
   logic                          bout_r;
   logic                          zero_r;
   logic [SLICE-1:0]              d;
   logic                          bo;
   logic                          last;

   sub_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .x  (a_r[cnt]),
      .y  (b_r[cnt]),
      .bi (borrow),
      .d  (d),
      .bo (bo)
   );

   assign last = (cnt == CW'(NSLICE - 1));

   // Result as it will look once the current slice lands.
   always_comb begin
      diff_nx      = diff_r;
      diff_nx[cnt] = d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         a_r         <= '0;
         b_r         <= '0;
         diff_r      <= '0;
         cnt         <= '0;
         borrow      <= 1'b0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         bout_r      <= 1'b0;
         zero_r      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               in_ready_r <= 1'b1;
               if (bus.in_valid && in_ready_r) begin
                  a_r        <= bus.a;
                  b_r        <= bus.b;
                  borrow     <= bus.bin;
                  cnt        <= '0;
                  in_ready_r <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               diff_r[cnt] <= d;
               borrow      <= bo;
               cnt         <= cnt + 1'b1;
               if (last) begin
                  bout_r      <= bo;
                  zero_r      <= (diff_nx == '0);
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.diff      = diff_r;
   assign bus.bout      = bout_r;
   assign bus.zero      = zero_r;

endmodule

// File: doc/seq_sub_64.md
Name: seq_sub_64

Overview:
- Multi-cycle 64-bit subtractor that computes a - b - bin. It is the inverse operation of the team's 64-bit conditional-sum adder.
- Operates serially, one SLICE-bit slice per clock, LSB slice first, with a ripple borrow register between slices.
- Valid/ready handshakes on input and output, so it drops into the same datapath as the adder blocks where area matters more than latency.

Parameters:
- WIDTH, 64: operand and result width in bits.
- SLICE, 16: bits processed per clock. WIDTH must be an integer multiple of SLICE, enforced by an elaboration-time check. NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  diff, bout, zero are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out of the MSB; 1 iff unsigned a < b + bin.
- zero  output  1  1 iff diff == 0.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst).
- Reset values: in_ready=0 during the reset cycle and 1 from the first cycle after rst deasserts; out_valid=0; diff=0; bout=0; zero=0; state=IDLE; slice counter=0; borrow register=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, bin into internal registers, load borrow register with bin, clear the counter, go to RUN.
  - RUN: in_ready=0. Each cycle, slice i (bits i*SLICE+SLICE-1 : i*SLICE) computes a_i - b_i - borrow. The result goes into diff slice i and the new borrow into the borrow register. The counter increments. After slice NSLICE-1, go to DONE.
  - DONE: out_valid=1, with bout = final borrow and zero = (diff==0). On out_ready go to IDLE, so in_ready is high the next cycle.
- Latency: operands accepted at edge k; out_valid rises after edge k+NSLICE (4 cycles at the defaults). Throughput is one result per NSLICE+2 cycles when out_ready is held high.
- Output stability: diff, bout and zero are registered and hold stable for as long as out_valid=1 and out_ready=0. Their values are don't-care while out_valid=0; diff updates slice by slice during RUN.
- No bypass: while in RUN or DONE, in_valid is ignored. The block is not pipelined, so a new operand is never accepted in the same cycle a result is consumed.
- Arithmetic: pure unsigned modulo-2^WIDTH. Signed callers interpret diff as two's complement; no overflow flag is produced.
- Boundaries:
  - a == b with bin=1 gives all-ones and bout=1.
  - a=0, b=0, bin=0 gives zero=1 and bout=0.
  - A borrow must propagate across every slice boundary.
- Reset mid-operation: rst in RUN or DONE aborts the operation. The result is discarded, outputs take their reset values next cycle, and no out_valid pulse is emitted.
- rst takes priority over every handshake in the same cycle.

Decomposition:
- Shared package sub_pkg:
  - state enum {IDLE, RUN, DONE};
  - WIDTH/SLICE defaults;
  - a function computing NSLICE and the counter width as $clog2(NSLICE), minimum 1.
- One sub-module, sub_slice: combinational SLICE-bit subtractor with ports x, y, bi, d, bo. It is instantiated once and muxed by the slice counter. It is reusable by the team's adder/subtractor blocks.

Test Plan:
- a=5, b=2, bin=0 -> after 4 cycles: diff=3, bout=0, zero=0.
- a=1, b=1, bin=0 -> diff=0, zero=1, bout=0. Also a=20, b=20, bin=1 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, zero=0.
- a=1228, b=1238, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFF6, bout=1. Also a=25623210, b=222340, bin=0 -> diff=25400870, bout=0.
- Cross-slice borrow: a=0x0000_0001_0000_0000, b=1, bin=0 -> diff=0x0000_0000_FFFF_FFFF, bout=0. Also a=0, b=0, bin=1 -> all-ones, bout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> diff/bout/zero unchanged, in_ready=0, and an in_valid pulse is ignored. Raise out_ready -> in_ready=1 the next cycle.
- Reset mid-run: assert rst 2 cycles after accept -> out_valid stays 0 and diff=0. in_ready=1 the cycle after rst drops. Then a=75, b=75, bin=1 completes normally with diff=all-ones.
